// File: rtl/lcd_char_feeder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_feeder
// Purpose  : Character FIFO, cursor tracker and command sequencer feeding an
//            HD44780 4-bit byte-level controller.
// Revision : 1.0 - initial release
// ============================================================================

module lcd_char_feeder #(
    parameter int DEPTH   = 8,
    parameter int COLS    = 16,
    parameter int ROWS    = 2,
    parameter int CLR_CYC = 82000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ch_valid,
    input  logic [7:0]             ch_data,
    output logic                   ch_ready,
    input  logic                   clr_req,
    input  logic                   init_done,
    output logic                   byte_go,
    output logic                   byte_is_data,
    output logic [7:0]             byte_val,
    input  logic                   byte_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [5:0]             cur_col,
    output logic                   cur_row
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(CLR_CYC - 1);
    localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
    localparam logic [7:0]    NEWLINE   = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CHR  = 3'd2,
        S_CLR  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      head;
    logic            push;
    logic            pop;
    logic            nonempty;
    logic            head_is_nl;
    logic            need_addr;
    logic            clr_pending;
    logic            next_row;
    logic [WW-1:0]   wait_cnt;

    assign head       = mem[rd_ptr];
    assign nonempty   = (fifo_count != '0);
    assign head_is_nl = (head == NEWLINE);
    assign ch_ready   = (fifo_count != FULL);
    assign push       = ch_valid && ch_ready;
    assign next_row   = (ROWS == 2) ? ~cur_row : 1'b0;

    // Pops come from newline consumption in IDLE or a finished character byte.
    assign pop = (state == S_IDLE && init_done && !clr_pending && nonempty && head_is_nl)
              || (state == S_CHR && byte_go && byte_done);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ch_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Each send state raises byte_go on its first cycle, then waits for done.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= S_IDLE;
            byte_go      <= 1'b0;
            byte_is_data <= 1'b0;
            byte_val     <= 8'h00;
            cur_col      <= 6'd0;
            cur_row      <= 1'b0;
            need_addr    <= 1'b1;
            clr_pending  <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (clr_req) begin
                clr_pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (init_done) begin
                        if (clr_pending) begin
                            state <= S_CLR;
                        end else if (nonempty && head_is_nl) begin
                            cur_col   <= 6'd0;
                            cur_row   <= next_row;
                            need_addr <= 1'b1;
                        end else if (nonempty && need_addr) begin
                            state <= S_ADDR;
                        end else if (nonempty) begin
                            state <= S_CHR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!byte_go) begin
                        byte_go      <= 1'b1;
                        byte_is_data <= 1'b0;
                        byte_val     <= 8'h80 | {1'b0, cur_row, cur_col};
                    end else if (byte_done) begin
                        byte_go   <= 1'b0;
                        need_addr <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_CHR: begin
                    if (!byte_go) begin
                        byte_go      <= 1'b1;
                        byte_is_data <= 1'b1;
                        byte_val     <= head;
                    end else if (byte_done) begin
                        byte_go <= 1'b0;
                        state   <= S_IDLE;
                        if (cur_col == LAST_COL) begin
                            cur_col   <= 6'd0;
                            cur_row   <= next_row;
                            need_addr <= 1'b1;
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    if (!byte_go) begin
                        byte_go      <= 1'b1;
                        byte_is_data <= 1'b0;
                        byte_val     <= 8'h01;
                        if (!clr_req) begin
                            clr_pending <= 1'b0;
                        end
                    end else if (byte_done) begin
                        byte_go   <= 1'b0;
                        cur_col   <= 6'd0;
                        cur_row   <= 1'b0;
                        need_addr <= 1'b1;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_char_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_feeder
// Purpose  : Self-checking bench: controller responder with byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_lcd_char_feeder;

    localparam int DEPTH    = 8;
    localparam int COLS     = 16;
    localparam int ROWS     = 2;
    localparam int CLR_CYC  = 40;
    localparam int RESP_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ch_valid = 1'b0;
    logic [7:0] ch_data = 8'h00;
    logic       clr_req = 1'b0;
    logic       init_done = 1'b0;
    logic       byte_done = 1'b0;
    logic       ch_ready;
    logic       byte_go;
    logic       byte_is_data;
    logic [7:0] byte_val;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [5:0] cur_col;
    logic       cur_row;

    lcd_char_feeder #(
        .DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .clr_req(clr_req), .init_done(init_done),
        .byte_go(byte_go), .byte_is_data(byte_is_data), .byte_val(byte_val),
        .byte_done(byte_done), .fifo_count(fifo_count), .cur_col(cur_col),
        .cur_row(cur_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_check = 0;
    int         n_pass  = 0;
    logic [8:0] exp_q[$];
    int         rise_q[$];
    int         done_q[$];
    int         stab_err = 0;
    int         man_req = 0;
    int         man_ack = 0;
    logic       resp_en = 1'b1;
    logic       model_en = 1'b0;
    int         m_col = 0;
    int         m_row = 0;
    logic       m_need = 1'b1;
    int         b_r = 0;
    int         b_d = 0;
    int         last_wr = 0;
    int         acc = 0;

    typedef struct {
        logic       rst_first;
        logic [7:0] ch;
        int         n;
        logic [8:0] e0;
        logic [8:0] e1;
        int         ecol;
        int         erow;
        int         g2;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_check++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_check++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, val, lo, hi);
    endtask

    // Reference cursor model for the longer streams.
    task automatic model_push(input logic [7:0] c);
        if (c == 8'h0A) begin
            m_col = 0; m_row = (m_row + 1) % ROWS; m_need = 1'b1;
        end else begin
            if (m_need) exp_q.push_back(9'h080 | 9'(m_row * 64 + m_col));
            m_need = 1'b0;
            exp_q.push_back({1'b1, c});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0; m_row = (m_row + 1) % ROWS; m_need = 1'b1;
            end
        end
    endtask

    task automatic run_responder();
        int         hold = 0;
        logic       prev = 1'b0;
        logic [8:0] held = '0;
        logic [8:0] want;
        forever begin
            @(negedge clk);
            byte_done = 1'b0;
            if (rst_n) begin
                hold = 0; prev = 1'b0;
            end else if (byte_go) begin
                if (!prev) begin
                    rise_q.push_back(cyc);
                    held = {byte_is_data, byte_val};
                    hold = 0;
                end else if ({byte_is_data, byte_val} != held) begin
                    stab_err++;
                end
                prev = 1'b1;
                if ((resp_en && hold >= RESP_LAT) || (!resp_en && man_req != man_ack)) begin
                    if (exp_q.size() == 0) begin
                        n_check++;
                        $display("FAIL unexpected_byte: got 0x%0h, want none", {byte_is_data, byte_val});
                    end else begin
                        want = exp_q.pop_front();
                        check("byte", 32'({byte_is_data, byte_val}), 32'(want));
                    end
                    byte_done = 1'b1;
                    done_q.push_back(cyc + 1);
                    if (!resp_en) man_ack++;
                    hold = 0;
                end else begin
                    hold++;
                end
            end else begin
                prev = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1; ch_valid = 1'b0; clr_req = 1'b0;
        @(negedge clk);
        check("rst_byte_go", 32'(byte_go), 0);
        check("rst_is_data", 32'(byte_is_data), 0);
        check("rst_byte_val", 32'(byte_val), 0);
        check("rst_ch_ready", 32'(ch_ready), 1);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_cur_col", 32'(cur_col), 0);
        check("rst_cur_row", 32'(cur_row), 0);
        exp_q.delete();
        m_col = 0; m_row = 0; m_need = 1'b1;
        b_r = rise_q.size(); b_d = done_q.size();
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic write_char(input logic [7:0] c);
        int n = 0;
        ch_valid = 1'b1; ch_data = c;
        while (!ch_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("write_timeout", 32'(ch_ready), 1);
        else begin
            last_wr = cyc + 1;
            if (model_en) model_push(c);
        end
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic step();
        if (ch_valid && ch_ready) begin
            acc++;
            if (model_en) model_push(ch_data);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || byte_go) && n < 3000) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    function automatic int gap(input int j);
        if (rise_q.size() > b_r + j && done_q.size() > b_d + j - 1)
            return rise_q[b_r + j] - done_q[b_d + j - 1];
        return -1;
    endfunction

    initial begin
        int n;
        logic saw_go;
        vt[0] = '{1'b1, 8'h41, 2, 9'h080, 9'h141, 1, 0, 0};
        vt[1] = '{1'b0, 8'h42, 1, 9'h142, 9'h000, 2, 0, 2};
        vt[2] = '{1'b1, 8'h58, 2, 9'h080, 9'h158, 1, 0, 0};
        vt[3] = '{1'b0, 8'h0A, 0, 9'h000, 9'h000, 0, 1, 0};
        vt[4] = '{1'b0, 8'h59, 2, 9'h0C0, 9'h159, 1, 1, 3};
        fork run_responder(); join_none
        init_done = 1'b1;

        // Table: "AB" and "X\nY", each group starting from reset.
        for (int i = 0; i < 5; i++) begin
            int t_first;
            if (vt[i].rst_first) begin do_reset(); model_en = 1'b0; end
            if (vt[i].n > 0) exp_q.push_back(vt[i].e0);
            if (vt[i].n > 1) exp_q.push_back(vt[i].e1);
            write_char(vt[i].ch);
            if (vt[i].rst_first) t_first = last_wr;
            if (i == 4 || vt[(i + 1) % 5].rst_first) begin
                drain("table");
                check("tbl_col", 32'(cur_col), 32'(vt[i].ecol));
                check("tbl_row", 32'(cur_row), 32'(vt[i].erow));
                check_range("first_go_latency", (rise_q.size() > b_r) ? rise_q[b_r] - t_first : -1, 2, 2);
                check_range("gap_byte1", gap(1), 2, 2);
                check_range("gap_byte2", gap(2), vt[i].g2, vt[i].g2);
            end
        end

        // Line wrap across both rows and back.
        do_reset(); model_en = 1'b1;
        for (int i = 0; i < 17; i++) write_char(8'h61 + 8'(i));
        drain("wrap17");
        check("wrap17_col", 32'(cur_col), 1);
        check("wrap17_row", 32'(cur_row), 1);
        for (int i = 0; i < 16; i++) write_char(8'h41 + 8'(i));
        drain("wrap33");
        check("wrap33_col", 32'(cur_col), 1);
        check("wrap33_row", 32'(cur_row), 0);

        // Clear during a character, then a second clear during the wait.
        do_reset(); model_en = 1'b0;
        exp_q.push_back(9'h080); exp_q.push_back(9'h150); exp_q.push_back(9'h001);
        exp_q.push_back(9'h001); exp_q.push_back(9'h080); exp_q.push_back(9'h151);
        write_char(8'h50);
        write_char(8'h51);
        n = 0;
        while (!(byte_go && byte_is_data) && n < 100) begin @(negedge clk); n++; end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (done_q.size() < b_d + 3 && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        drain("clear");
        check_range("clr_wait_gap1", gap(3), CLR_CYC + 2, CLR_CYC + 3);
        check_range("clr_wait_gap2", gap(4), CLR_CYC + 2, CLR_CYC + 3);
        check("clr_col", 32'(cur_col), 1);
        check("clr_row", 32'(cur_row), 0);

        // Stall the controller and fill the FIFO.
        do_reset(); model_en = 1'b1; resp_en = 1'b0; acc = 0;
        ch_data = 8'h61; ch_valid = 1'b1;
        repeat (14) step();
        check("full_accepted", 32'(acc), DEPTH);
        check("full_ready", 32'(ch_ready), 0);
        check("full_count", 32'(fifo_count), DEPTH);
        check("full_addr_go", 32'({byte_go, byte_is_data}), 2);
        man_req++;
        n = 0;
        while (!(byte_go && byte_is_data) && n < 50) begin step(); n++; end
        check("full_after_addr", 32'(fifo_count), DEPTH);
        man_req++;
        n = 0;
        while (fifo_count == DEPTH && n < 50) begin step(); n++; end
        check("full_pop_count", 32'(fifo_count), DEPTH - 1);
        check("full_pop_refused", 32'(acc), DEPTH);
        step();
        ch_valid = 1'b0;
        check("full_refill", 32'(fifo_count), DEPTH);
        resp_en = 1'b1;
        drain("full");

        // init_done low blocks output; then reset in the middle of a byte.
        init_done = 1'b0;
        do_reset(); model_en = 1'b1;
        write_char(8'h6B); write_char(8'h6C); write_char(8'h6D);
        saw_go = 1'b0;
        repeat (30) begin @(negedge clk); saw_go |= byte_go; end
        check("noinit_go", 32'(saw_go), 0);
        check("noinit_count", 32'(fifo_count), 3);
        init_done = 1'b1;
        drain("noinit");
        resp_en = 1'b0;
        write_char(8'h7A);
        n = 0;
        while (!byte_go && n < 50) begin @(negedge clk); n++; end
        check("midbyte_go", 32'(byte_go), 1);
        do_reset();
        resp_en = 1'b1;

        check("byte_stable", 32'(stab_err), 0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/lcd_char_feeder.md
# lcd_char_feeder

Upstream feeder for the HD44780 4-bit LCD controller. Accepts a character stream from the host side, buffers it in a small FIFO, and tracks the cursor on a COLS x ROWS panel. Emits set-DDRAM-address commands at start, newline and line wrap, plus clear-display commands with the required post-clear wait. Presents one byte at a time on the controller's byte_go / byte_is_data / byte_val / byte_done interface.

## Interface
- DEPTH, 8: FIFO depth in entries; power of 2, at least 2.
- COLS, 16: characters per row; 2..64.
- ROWS, 2: row count; 1 or 2. Row base addresses are 0x00 and 0x40.
- CLR_CYC, 82000: idle cycles after a clear command's byte_done (1.64 ms at 50 MHz).

- clk  in  1  single clock domain, rising edge.
- rst_n  in  1  synchronous, active-high reset. Sampled 1 on a rising edge resets the block.
- ch_valid  in  1  host offers ch_data.
- ch_data  in  8  character code; 0x0A = newline, all other values are printable.
- ch_ready  out  1  FIFO can accept; a write occurs when ch_valid && ch_ready.
- clr_req  in  1  one-cycle request to clear the display and home the cursor.
- init_done  in  1  controller init sequence complete; no byte is issued while this is 0.
- byte_go  out  1  byte request; held high until byte_done.
- byte_is_data  out  1  1 = character (RS=1), 0 = command.
- byte_val  out  8  byte to send.
- byte_done  in  1  one-cycle pulse from the controller: byte finished.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- cur_col  out  6  column of the next character.
- cur_row  out  1  row of the next character.

## Operation
- FIFO: write pointer, read pointer and count; ch_ready = (count != DEPTH).
  - A write while full is refused even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave count unchanged.
- clr_pending: sticky flag, set by clr_req, cleared when the clear command is issued. Clear does not flush the FIFO.
- need_addr flag: set by reset, clear, newline and wrap; cleared after an address command completes.
- FSM states:
  - IDLE: stay while init_done=0. Otherwise, in priority order:
    - clr_pending -> CLR_SEND.
    - FIFO head is 0x0A -> pop it, set col=0, row=(row+1)%ROWS, set need_addr, stay in IDLE (no byte issued).
    - FIFO non-empty and need_addr -> ADDR_SEND.
    - FIFO non-empty -> CHR_SEND.
  - ADDR_SEND: byte_go=1, is_data=0, val=0x80 | (row?0x40:0x00) + col. On byte_done: clear need_addr, go to IDLE.
  - CHR_SEND: byte_go=1, is_data=1, val=FIFO head. On byte_done: pop the FIFO. If col==COLS-1, set col=0, advance row mod ROWS and set need_addr; otherwise col+1. Go to IDLE.
  - CLR_SEND: byte_go=1, is_data=0, val=0x01. On byte_done: col=0, row=0, set need_addr, load the wait counter, go to CLR_WAIT.
  - CLR_WAIT: count CLR_CYC cycles with byte_go=0, then go to IDLE. A clr_req arriving here sets clr_pending again.
- byte_is_data and byte_val stay stable for the whole time byte_go is high.
- A byte_done pulse seen while byte_go=0 is ignored.

## Timing
- Reset values:
  - ch_ready=1, byte_go=0, byte_is_data=0, byte_val=0x00.
  - fifo_count=0, cur_col=0, cur_row=0.
  - need_addr=1, clr_pending=0, state IDLE.
- Registered outputs; byte_go rises the cycle after IDLE makes its decision.
- Character written at edge t into an empty FIFO, no address needed: IDLE decides at t+1, byte_go=1 from t+2.
- byte_done sampled at edge d: byte_go=0 from d+1. The next byte_go rises no earlier than d+2 (one IDLE cycle).
- Newline consumption takes exactly one IDLE cycle.
- After a clear command's byte_done at edge d, the next byte_go rises no earlier than d+CLR_CYC+2.
- Reset asserted mid-byte: byte_go=0 on the next edge; any in-flight byte is abandoned.

## Test plan
- Reset, init_done=1, write "AB" -> byte sequence (cmd 0x80), (data 0x41), (data 0x42); afterwards cur_col=2.
- COLS=16, ROWS=2: write 17 chars -> cmd 0x80, 16 data bytes, cmd 0xC0, 1 data byte. Then write 16 more -> wrap to row 0 with a new cmd 0x80.
- Write "X", 0x0A, "Y" -> 0x80, 'X', 0xC0, 'Y'. The newline itself issues no byte; cur_row=1.
- clr_req during a character transfer -> transfer completes, then 0x01 is sent, then byte_go stays low for CLR_CYC cycles, then 0x80 is sent before the next character.
- Hold byte_done low with ch_valid constant -> exactly DEPTH writes accepted, ch_ready=0, fifo_count=DEPTH. A simultaneous write+pop at full is refused; count drops to DEPTH-1.
- init_done=0 with the FIFO loaded -> byte_go stays 0. Assert rst_n mid-byte -> all outputs return to reset values on the next edge.
